// File: rtl/decay_scheduler_pkg.sv
// Shared definitions for the decay scheduler: FSM states, decay codes and
// IEEE-754 single-precision field positions.
package decay_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_t;

  localparam logic [3:0] RATE_DIV1  = 4'b0001;
  localparam logic [3:0] RATE_DIV2  = 4'b0010;
  localparam logic [3:0] RATE_DIV4  = 4'b0100;
  localparam logic [3:0] RATE_DIV8  = 4'b1000;
  localparam logic [3:0] RATE_RESET = RATE_DIV2;

  localparam int unsigned FP_SIGN_BIT = 31;
  localparam int unsigned FP_EXP_MSB  = 30;
  localparam int unsigned FP_EXP_LSB  = 23;
  localparam int unsigned FP_EXP_W    = FP_EXP_MSB - FP_EXP_LSB + 1;

  // Map a decay code onto an exponent decrement; unknown codes mean no decay.
  function automatic logic [1:0] rate_shift(input logic [3:0] code);
    case (code)
      RATE_DIV2: rate_shift = 2'd1;
      RATE_DIV4: rate_shift = 2'd2;
      RATE_DIV8: rate_shift = 2'd3;
      default:   rate_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fp_exp_decay.sv
// Divides a single-precision value by 1/2/4/8 by decrementing its exponent.
// Inf/NaN and zero/denormal pass through; underflow flushes to signed zero.
module fp_exp_decay
  import decay_scheduler_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        rate,
  output logic [DATA_W-1:0] dout
);

  logic [FP_EXP_W-1:0] exp_in;
  logic [FP_EXP_W-1:0] k_ext;

  // Exponent decrement with special-value pass-through and flush to zero
  always_comb begin
    exp_in = din[FP_EXP_MSB:FP_EXP_LSB];
    k_ext  = {{(FP_EXP_W-2){1'b0}}, rate_shift(rate)};
    dout   = din;
    if (exp_in != '0 && exp_in != '1) begin
      if (exp_in <= k_ext) begin
        dout              = '0;
        dout[FP_SIGN_BIT] = din[FP_SIGN_BIT];
      end else begin
        dout[FP_EXP_MSB:FP_EXP_LSB] = exp_in - k_ext;
      end
    end
  end

endmodule

// File: rtl/decay_scheduler.sv
// Sweeps every neuron once per timestep: read potential, decay it by the
// neuron's configured rate, write it back, then pulse done.
module decay_scheduler
  import decay_scheduler_pkg::*;
#(
  parameter int NUM_NEURONS = 64,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timestep_start,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int LAST_I = NUM_NEURONS - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_I[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   TBL_SIZE  = NUM_NEURONS[ADDR_W:0];

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   decayed;
  logic [3:0]          cur_rate;
  logic [3:0]          rate_tbl [NUM_NEURONS];

  assign mem_addr  = cnt_q;
  assign mem_wdata = result_q;
  assign cur_rate  = rate_tbl[cnt_q[IDX_W-1:0]];

  fp_exp_decay #(.DATA_W(DATA_W)) u_decay (
    .din  (mem_rdata),
    .rate (cur_rate),
    .dout (decayed)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and memory handshake outputs
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (timestep_start) state_d = RD_REQ;
      end
      RD_REQ: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        busy    = 1'b1;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        busy    = 1'b1;
        if (mem_gnt) state_d = (cnt_q == LAST_ADDR) ? FINISH : RD_REQ;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Neuron counter and registered decay result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && timestep_start) cnt_q <= '0;
      if (state_q == WR_REQ && mem_gnt && cnt_q != LAST_ADDR) cnt_q <= cnt_q + 1'b1;
      if (state_q == RD_WAIT) result_q <= decayed;
    end
  end

  // Sticky flag for a start that arrives while a sweep is in progress
  always_ff @(posedge clk) begin
    if (rst)                                  overrun <= 1'b0;
    else if (timestep_start && state_q != IDLE) overrun <= 1'b1;
  end

  // Per-neuron decay-rate table; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) rate_tbl[i] <= RATE_RESET;
    end else if (cfg_we && ({1'b0, cfg_addr} < TBL_SIZE)) begin
      rate_tbl[cfg_addr[IDX_W-1:0]] <= cfg_rate;
    end
  end

endmodule

// File: tb/tb_decay_scheduler.sv
// Bench for decay_scheduler with a 4-neuron sweep, a logging memory model
// and a real-arithmetic reference for the decay.
module tb_decay_scheduler;

  localparam int NN = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          timestep_start = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_rate = '0;
  logic          mem_req;
  logic          mem_gnt = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done, overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   pre [NN];
  logic [3:0]    model_rate [NN];
  logic [AW-1:0] wlog_addr [$];
  logic [31:0]   wlog_data [$];
  logic [AW-1:0] rlog_addr [$];

  int            stall_n = 0;
  logic [AW-1:0] stall_addr = '0;
  int            wait_n = 0;
  int            stab_bad = 0;
  int            stab_chk = 0;
  logic [AW-1:0] held_addr = '0;
  logic [31:0]   held_wdata = '0;
  logic          held_we = 1'b0;

  decay_scheduler #(
    .NUM_NEURONS (NN),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .timestep_start (timestep_start),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_rate       (cfg_rate),
    .mem_req        (mem_req),
    .mem_gnt        (mem_gnt),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  // Memory: completed accesses are logged; read data is valid only the cycle after a granted read
  always @(posedge clk) begin
    mem_rdata <= $urandom();
    if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
      if (mem_we) begin
        wlog_addr.push_back(mem_addr);
        wlog_data.push_back(mem_wdata);
      end else begin
        rlog_addr.push_back(mem_addr);
        mem_rdata <= (int'(mem_addr) < NN) ? pre[mem_addr[1:0]] : 32'h0;
      end
    end
  end

  // Grant responder: optionally withholds grant for one address and watches request stability
  always @(negedge clk) begin
    if (mem_req !== 1'b1) begin
      mem_gnt = 1'b0;
      wait_n  = 0;
    end else begin
      if (mem_gnt) wait_n = 0;
      if (wait_n == 0) begin
        held_addr  = mem_addr;
        held_wdata = mem_wdata;
        held_we    = mem_we;
      end else begin
        stab_chk++;
        if (mem_addr !== held_addr || mem_we !== held_we || (held_we && mem_wdata !== held_wdata))
          stab_bad++;
      end
      if (stall_n > 0 && mem_addr == stall_addr && wait_n < stall_n) begin
        mem_gnt = 1'b0;
        wait_n++;
      end else begin
        mem_gnt = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decay: divide the value by the rate's divisor in real arithmetic
  function automatic logic [31:0] ref_decay(input logic [31:0] v, input logic [3:0] code);
    int          div;
    int          e;
    real         r;
    logic [63:0] d;
    case (code)
      4'd2:    div = 2;
      4'd4:    div = 4;
      4'd8:    div = 8;
      default: div = 1;
    endcase
    e = int'(v[30:23]);
    if (e == 0 || e == 255) return v;
    d = {v[31], 11'(e - 127 + 1023), v[22:0], 29'b0};
    r = $bitstoreal(d) / div;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return {v[31], 31'b0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 5))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'($urandom_range(1, 4));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  function automatic logic [3:0] rand_rate();
    case ($urandom_range(0, 4))
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    timestep_start = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NN; i++) model_rate[i] = 4'b0010;
  endtask

  task automatic cfg(input int addr, input logic [3:0] rate);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_rate = rate;
    if (addr < NN) model_rate[addr] = rate;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pulses start and counts cycles until done; extra_at > 0 re-pulses start mid-sweep
  task automatic sweep(input int extra_at, output int lat);
    @(negedge clk);
    timestep_start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      timestep_start = (extra_at > 0 && lat == extra_at);
      if (lat == 1) chk("busy_after_start", 32'(busy), 32'd1);
    end while (done !== 1'b1 && lat < 500);
    timestep_start = 1'b0;
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag, input int w0, input int r0);
    chk({tag, "_nwrites"}, 32'(wlog_addr.size() - w0), 32'(NN));
    chk({tag, "_nreads"}, 32'(rlog_addr.size() - r0), 32'(NN));
    if (wlog_addr.size() - w0 == NN) begin
      for (int i = 0; i < NN; i++) begin
        chk($sformatf("%s_waddr%0d", tag, i), 32'(wlog_addr[w0+i]), 32'(i));
        chk($sformatf("%s_wdata%0d", tag, i), wlog_data[w0+i], ref_decay(pre[i], model_rate[i]));
      end
    end
  endtask

  initial begin
    int lat, w0, r0, s0, c0, k;
    for (int i = 0; i < NN; i++) begin
      pre[i] = '0;
      model_rate[i] = 4'b0010;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Uniform value, reset rates (/2), continuous grant
    for (int i = 0; i < NN; i++) pre[i] = 32'h41DEB852;
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(0, lat);
    chk("basic_latency", 32'(lat), 32'd13);
    check_writes("basic", w0, r0);
    if (wlog_data.size() > w0) chk("basic_const", wlog_data[w0], 32'h415EB852);
    chk("basic_overrun", 32'(overrun), 32'd0);

    // Neuron 2 at /8
    cfg(2, 4'b1000);
    pre[0] = 32'h41DEB852; pre[1] = 32'h3F800000; pre[2] = 32'hC1200000; pre[3] = 32'h40490FDB;
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(0, lat);
    chk("div8_latency", 32'(lat), 32'd13);
    check_writes("div8", w0, r0);
    if (wlog_data.size() > w0 + 2) chk("div8_const", wlog_data[w0+2], 32'hBFA00000);

    // Underflow to zero and Inf pass-through; out-of-range cfg ignored
    cfg(0, 4'b0100);
    cfg(1, 4'b1000);
    cfg(NN, 4'b0001);
    cfg(4095, 4'b0001);
    pre[0] = 32'h00800000; pre[1] = 32'h7F800000; pre[2] = 32'h80000001; pre[3] = 32'h81000000;
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(0, lat);
    check_writes("special", w0, r0);
    if (wlog_data.size() > w0 + 1) begin
      chk("special_zero", wlog_data[w0], 32'h00000000);
      chk("special_inf", wlog_data[w0+1], 32'h7F800000);
    end

    // Randomized rates and values
    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 3) == 0) cfg($urandom_range(NN, 4095), rand_rate());
        else                           cfg($urandom_range(0, NN - 1), rand_rate());
      end
      for (int i = 0; i < NN; i++) pre[i] = rand_val();
      w0 = wlog_addr.size(); r0 = rlog_addr.size();
      sweep(0, lat);
      chk($sformatf("rand%0d_latency", t), 32'(lat), 32'd13);
      check_writes($sformatf("rand%0d", t), w0, r0);
    end

    // Grant withheld 5 cycles on both accesses of neuron 1
    stall_addr = AW'(1); stall_n = 5;
    for (int i = 0; i < NN; i++) pre[i] = rand_val();
    s0 = stab_bad; c0 = stab_chk;
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(0, lat);
    stall_n = 0;
    chk("stall_latency", 32'(lat), 32'd23);
    check_writes("stall", w0, r0);
    chk("stall_stable", 32'(stab_bad - s0), 32'd0);
    chk("stall_checks", 32'(stab_chk - c0), 32'd10);

    // Start pulsed mid-sweep sets overrun only
    for (int i = 0; i < NN; i++) pre[i] = rand_val();
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(5, lat);
    chk("ovr_latency", 32'(lat), 32'd13);
    check_writes("ovr", w0, r0);
    chk("ovr_flag", 32'(overrun), 32'd1);
    do_reset();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Reset while neuron 1 waits in WR_REQ
    stall_addr = AW'(1); stall_n = 5;
    for (int i = 0; i < NN; i++) pre[i] = rand_val();
    w0 = wlog_addr.size();
    @(negedge clk);
    timestep_start = 1'b1;
    @(negedge clk);
    timestep_start = 1'b0;
    lat = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b1 && mem_addr == AW'(1)) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_reached_wr1", 32'(lat < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stall_n = 0;
    for (int i = 0; i < NN; i++) model_rate[i] = 4'b0010;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_nwrites", 32'(wlog_addr.size() - w0), 32'd1);
    if (wlog_addr.size() > w0) chk("abort_waddr", 32'(wlog_addr[w0]), 32'd0);
    w0 = wlog_addr.size(); r0 = rlog_addr.size();
    sweep(0, lat);
    chk("restart_latency", 32'(lat), 32'd13);
    check_writes("restart", w0, r0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
